// File: rtl/inv_cipher_iter_if.sv
// Block handshake bundle for the iterative AES inverse cipher: ciphertext and
// key schedule in, plaintext out, each direction with its own ready/valid pair.
interface inv_cipher_iter_if #(
   parameter int Nr = 10
);
   logic [127:0]            in;
   logic [128*(Nr+1)-1:0]   word;
   logic                    in_valid;
   logic                    in_ready;
   logic [127:0]            out;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in, word, in_valid, out_ready,
      input  in_ready, out, out_valid
   );

   modport slave (
      input  in, word, in_valid, out_ready,
      output in_ready, out, out_valid
   );
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock through a single
// shared InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns datapath.

module inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] InvTable [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign y = InvTable[a];
endmodule

module inv_mix_col (
   input  logic [31:0] col,
   output logic [31:0] res
);
   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulB(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] mulD(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mulE(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = col;

   assign res[31:24] = mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3);
   assign res[23:16] = mul9(a0) ^ mulE(a1) ^ mulB(a2) ^ mulD(a3);
   assign res[15:8]  = mulD(a0) ^ mul9(a1) ^ mulE(a2) ^ mulB(a3);
   assign res[7:0]   = mulB(a0) ^ mulD(a1) ^ mul9(a2) ^ mulE(a3);
endmodule

module inv_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic            clk,
   input  logic            rst,
   inv_cipher_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsmState;

   // An unsupported key-length/round-count pairing never accepts a block.
   localparam bit CfgLegal = (Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) ||
                             (Nk == 8 && Nr == 14);

   fsmState      fsmReg, fsmNext;
   logic [127:0] stateReg, stateNext;
   logic [127:0] outReg, outNext;
   logic         outValidReg, outValidNext;
   logic [3:0]   rcReg, rcNext;

   logic [127:0] roundKey [Nr+1];
   logic [127:0] subOut, arkOut, mixOut;

   genvar gi;
   generate
      for (gi = 0; gi <= Nr; gi++) begin : gKey
         assign roundKey[gi] = bus.word[128*(Nr+1)-1-128*gi -: 128];
      end

      // InvShiftRows is pure wiring: output byte (row, col) takes input (row, col-row).
      for (gi = 0; gi < 16; gi++) begin : gSub
         localparam int Row = gi % 4;
         localparam int Col = gi / 4;
         localparam int Src = 4 * ((Col + 4 - Row) % 4) + Row;
         inv_sbox uSbox (
            .a (stateReg[127-8*Src -: 8]),
            .y (subOut[127-8*gi -: 8])
         );
      end

      for (gi = 0; gi < 4; gi++) begin : gMix
         inv_mix_col uMix (
            .col (arkOut[127-32*gi -: 32]),
            .res (mixOut[127-32*gi -: 32])
         );
      end
   endgenerate

   assign arkOut = subOut ^ roundKey[rcReg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsmReg      <= IDLE;
         stateReg    <= '0;
         outReg      <= '0;
         outValidReg <= 1'b0;
         rcReg       <= '0;
      end else begin
         fsmReg      <= fsmNext;
         stateReg    <= stateNext;
         outReg      <= outNext;
         outValidReg <= outValidNext;
         rcReg       <= rcNext;
      end
   end

   always_comb begin
      fsmNext      = fsmReg;
      stateNext    = stateReg;
      outNext      = outReg;
      outValidNext = outValidReg;
      rcNext       = rcReg;
      case (fsmReg)
         IDLE: begin
            if (bus.in_valid && CfgLegal) begin
               stateNext = bus.in ^ roundKey[Nr];
               rcNext    = 4'(Nr - 1);
               fsmNext   = ROUND;
            end
         end
         ROUND: begin
            // The last round skips InvMixColumns and lands straight in the output register.
            if (rcReg != 4'd0) begin
               stateNext = mixOut;
               rcNext    = rcReg - 4'd1;
            end else begin
               outNext      = arkOut;
               outValidNext = 1'b1;
               fsmNext      = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               outValidNext = 1'b0;
               fsmNext      = IDLE;
            end
         end
         default: fsmNext = IDLE;
      endcase
   end

   assign bus.in_ready  = CfgLegal && (fsmReg == IDLE);
   assign bus.out       = outReg;
   assign bus.out_valid = outValidReg;
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed and round-trip bench for inv_cipher_iter at all three AES key sizes;
// key expansion and forward encryption are modelled here from first principles.
module tb_inv_cipher_iter;
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]    sel;
   logic [127:0]  inD;
   logic [1919:0] schedD;
   logic          vld;
   logic          outReady;

   inv_cipher_iter_if #(.Nr(10)) b0 ();
   inv_cipher_iter_if #(.Nr(12)) b1 ();
   inv_cipher_iter_if #(.Nr(14)) b2 ();

   assign b0.in = inD;
   assign b1.in = inD;
   assign b2.in = inD;
   assign b0.word = schedD[1919 -: 1408];
   assign b1.word = schedD[1919 -: 1664];
   assign b2.word = schedD;
   assign b0.in_valid = vld && (sel == 2'd0);
   assign b1.in_valid = vld && (sel == 2'd1);
   assign b2.in_valid = vld && (sel == 2'd2);
   assign b0.out_ready = outReady;
   assign b1.out_ready = outReady;
   assign b2.out_ready = outReady;

   inv_cipher_iter #(.Nk(4), .Nr(10)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   inv_cipher_iter #(.Nk(6), .Nr(12)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   inv_cipher_iter #(.Nk(8), .Nr(14)) dut2 (.clk(clk), .rst(rst), .bus(b2));

   logic [127:0] outS;
   logic         outValidS, inReadyS;
   assign outS      = (sel == 2'd0) ? b0.out : (sel == 2'd1) ? b1.out : b2.out;
   assign outValidS = (sel == 2'd0) ? b0.out_valid : (sel == 2'd1) ? b1.out_valid : b2.out_valid;
   assign inReadyS  = (sel == 2'd0) ? b0.in_ready : (sel == 2'd1) ? b1.in_ready : b2.in_ready;

   int errors = 0;
   int checks = 0;
   int txn = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model: GF arithmetic, S-box, key schedule, encrypt
   logic [7:0] sbox [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1919:0] r;
      int            nwords;
      nwords = 4 * (nk + 7);
      rcon = 8'h01;
      r = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < nwords; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subWord(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < nwords; i++) r[1919-32*i -: 32] = w[i];
      return r;
   endfunction

   function automatic logic [127:0] subB(input logic [127:0] x);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox[x[127-8*k -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] shiftR(input logic [127:0] x);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            r[127-8*(4*c+rw) -: 8] = x[127-8*(4*((c+rw)%4)+rw) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mixC(input logic [127:0] x);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = x[127-32*c -: 32];
         r[127-32*c -: 32] = {gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
                              a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                              a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                              gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
      end
      return r;
   endfunction

   function automatic logic [127:0] encrypt128(input logic [127:0] pt, input logic [1919:0] sch);
      logic [127:0] s;
      s = pt ^ sch[1919 -: 128];
      for (int rnd = 1; rnd < 10; rnd++) s = mixC(shiftR(subB(s))) ^ sch[1919-128*rnd -: 128];
      return shiftR(subB(s)) ^ sch[1919-1280 -: 128];
   endfunction

   // ---------------- stimulus helpers
   task automatic waitOut(output int lat);
      lat = 0;
      while (!outValidS && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic runBlock(input string label, input int s, input logic [127:0] ct,
                           input logic [255:0] key, output logic [127:0] pt, output int lat);
      sel    = 2'(s);
      inD    = ct;
      schedD = expandKey(key, 4 + 2*s);
      vld    = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      waitOut(lat);
      pt = outS;
      txn++;
      $display("txn %0d %s Nk=%0d ct=%h out=%h latency=%0d", txn, label, 4 + 2*s, ct, pt, lat);
   endtask

   typedef struct {
      string        name;
      int           s;
      logic [127:0] ct;
      logic [255:0] key;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [127:0] got;
      logic [127:0] c1Pt;
      logic [127:0] rtKeyLo, rtPt, rtCt;
      logic [1919:0] rtSched;
      int lat, waited, acc, prevAcc;

      vecs[0] = '{"aes128_c1", 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{"aes192_c2", 1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                  {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'h00112233445566778899aabbccddeeff};
      vecs[2] = '{"aes256_c3", 2, 128'h8ea2b7ca516745bfeafc49904b496089,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff};
      vecs[3] = '{"aes128_b", 0, 128'h3925841d02dc09fbdc118597196a0b32,
                  {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3243f6a8885a308d313198a2e0370734};

      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv, r1, r2, r3, r4;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
         sbox[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end

      rst = 1'b1; sel = 2'd0; inD = '0; schedD = '0; vld = 1'b0; outReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", outValidS, 1'b0);
      chk("reset out", outS, 128'h0);
      chk("reset in_ready", inReadyS, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Known-answer table across all key sizes.
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         runBlock(vecs[i].name, vecs[i].s, vecs[i].ct, vecs[i].key, got, lat);
         chk({vecs[i].name, " plaintext"}, got, vecs[i].pt);
         chk({vecs[i].name, " latency"}, lat, 10 + 2*vecs[i].s);
         @(posedge clk); #1;
         chk({vecs[i].name, " in_ready after"}, inReadyS, 1'b1);
         chk({vecs[i].name, " out_valid after"}, outValidS, 1'b0);
      end

      // Backpressure: output held, ingress refused, then simultaneous in_valid/out_ready.
      outReady = 1'b0;
      runBlock("backpressure", 0, vecs[0].ct, vecs[0].key, c1Pt, lat);
      chk("bp plaintext", c1Pt, vecs[0].pt);
      chk("bp latency", lat, 10);
      for (int i = 0; i < 5; i++) begin
         inD = ~vecs[0].ct;
         vld = 1'b1;
         @(posedge clk); #1;
         chk("bp hold out_valid", outValidS, 1'b1);
         chk("bp hold out", outS, vecs[0].pt);
         chk("bp hold in_ready", inReadyS, 1'b0);
      end
      inD = vecs[3].ct;
      schedD = expandKey(vecs[3].key, 4);
      outReady = 1'b1;
      @(posedge clk); #1;
      chk("bp release out_valid", outValidS, 1'b0);
      chk("bp release in_ready", inReadyS, 1'b1);
      chk("bp release out kept", outS, vecs[0].pt);
      @(posedge clk); #1;
      vld = 1'b0;
      chk("bp late accept in_ready", inReadyS, 1'b0);
      waitOut(lat);
      txn++;
      $display("txn %0d late_accept ct=%h out=%h latency=%0d", txn, vecs[3].ct, outS, lat);
      chk("late accept plaintext", outS, vecs[3].pt);
      chk("late accept latency", lat, 10);
      @(posedge clk); #1;

      // Asynchronous reset four cycles into a block, then a clean block.
      inD = vecs[0].ct;
      schedD = expandKey(vecs[0].key, 4);
      vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midreset out_valid", outValidS, 1'b0);
      chk("midreset out", outS, 128'h0);
      chk("midreset in_ready", inReadyS, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      runBlock("after_reset", 0, vecs[0].ct, vecs[0].key, got, lat);
      chk("after reset plaintext", got, vecs[0].pt);
      chk("after reset latency", lat, 10);
      @(posedge clk); #1;

      // Round trip: random blocks encrypted by the model, streamed back-to-back.
      sel = 2'd0;
      outReady = 1'b1;
      prevAcc = 0;
      for (int i = 0; i < 100; i++) begin
         rtKeyLo = {$urandom, $urandom, $urandom, $urandom};
         rtPt    = {$urandom, $urandom, $urandom, $urandom};
         rtSched = expandKey({rtKeyLo, 128'h0}, 4);
         rtCt    = encrypt128(rtPt, rtSched);
         inD     = rtCt;
         schedD  = rtSched;
         vld     = 1'b1;
         waited  = 0;
         while (!inReadyS && waited < 40) begin
            @(posedge clk); #1;
            waited++;
         end
         @(posedge clk); #1;
         acc = cyc;
         if (i > 0) chk("roundtrip accept spacing", acc - prevAcc, 12);
         prevAcc = acc;
         waitOut(lat);
         txn++;
         $display("txn %0d roundtrip pt=%h ct=%h out=%h latency=%0d", txn, rtPt, rtCt, outS, lat);
         chk("roundtrip plaintext", outS, rtPt);
      end
      vld = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
